// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit frame controller:
// FSM state encoding and parity-type constants.
package uart_tx_ctrl_pkg;

    // Frame controller states, 3-bit encoded
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity type selector values on PAR_TYP
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Only byte-wide frames are supported by the serializer
    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-source / serializer bundle of the UART transmit frame controller.
// master: the side providing bytes and the serializer bit stream.
// slave:  the frame controller itself.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_data;
    logic                  ser_done;
    logic                  ser_en;
    logic [DATA_WIDTH-1:0] SER_P_DATA;
    logic                  TX_OUT;
    logic                  BUSY;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, SER_P_DATA, TX_OUT, BUSY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, SER_P_DATA, TX_OUT, BUSY
    );
endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR of all data bits, inverted for odd parity.
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);
    assign o_parity = (^i_data) ^ i_par_typ;
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: latches a byte, sequences start/data/
// parity/stop bits through the serializer and drives the registered TX line.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int STOP_BITS  = 1
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave tx_bus
);
    // Stop counter value of the final stop cycle (STOP_BITS is 1 or 2)
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e             r_state;
    logic                  r_tx;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_ser_p_data;
    logic                  r_parity;
    logic                  r_par_en;
    logic                  r_stop_cnt;

    logic                  w_parity;
    logic                  w_last_stop;
    logic                  w_ser_en;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (tx_bus.P_DATA),
        .i_par_typ (tx_bus.PAR_TYP),
        .o_parity  (w_parity)
    );

    assign w_last_stop = (r_stop_cnt == STOP_LAST);

    // Serializer runs while the start bit is in the state register and
    // through the data bits; dropping it clears the serializer.
    assign w_ser_en = (r_state == ST_START) || (r_state == ST_DATA);

    assign tx_bus.ser_en     = w_ser_en;
    assign tx_bus.SER_P_DATA = r_ser_p_data;
    assign tx_bus.TX_OUT     = r_tx;
    assign tx_bus.BUSY       = r_busy;

    // Frame FSM with registered line mux, busy flag, byte/parity latches and stop counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_ser_p_data <= '0;
            r_parity     <= 1'b0;
            r_par_en     <= 1'b0;
            r_stop_cnt   <= 1'b0;
        end else begin
            // Line bit follows the state one cycle later
            case (r_state)
                ST_IDLE:   r_tx <= 1'b1;
                ST_START:  r_tx <= 1'b0;
                ST_DATA:   r_tx <= tx_bus.ser_data;
                ST_PARITY: r_tx <= r_parity;
                ST_STOP:   r_tx <= 1'b1;
                default:   r_tx <= 1'b1;
            endcase

            // Busy lines up with the line bits, so it stays high across
            // back-to-back frames because the state never visits IDLE.
            r_busy <= (r_state != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (tx_bus.DATA_VALID) begin
                        r_ser_p_data <= tx_bus.P_DATA;
                        r_par_en     <= tx_bus.PAR_EN;
                        r_parity     <= w_parity;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (tx_bus.ser_done) begin
                        r_state <= r_par_en ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    r_state <= ST_STOP;
                end
                ST_STOP: begin
                    if (w_last_stop) begin
                        r_stop_cnt <= 1'b0;
                        if (tx_bus.DATA_VALID) begin
                            r_ser_p_data <= tx_bus.P_DATA;
                            r_par_en     <= tx_bus.PAR_EN;
                            r_parity     <= w_parity;
                            r_state      <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: one- and two-stop-bit instances share stimulus,
// each fed by a behavioural serializer and checked cycle by cycle against a
// queue-of-line-bits reference model, plus directed frame captures.
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] p_data;
    logic       dv;
    logic       pe;
    logic       pt;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) if1 ();
    uart_tx_ctrl_if #(.DATA_WIDTH(8)) if2 ();

    assign if1.P_DATA     = p_data;
    assign if1.DATA_VALID = dv;
    assign if1.PAR_EN     = pe;
    assign if1.PAR_TYP    = pt;
    assign if2.P_DATA     = p_data;
    assign if2.DATA_VALID = dv;
    assign if2.PAR_EN     = pe;
    assign if2.PAR_TYP    = pt;

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
        .CLK    (clk),
        .RST    (rst),
        .tx_bus (if1.slave)
    );

    uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
        .CLK    (clk),
        .RST    (rst),
        .tx_bus (if2.slave)
    );

    // Behavioural serializers: bit 0 the cycle after ser_en rises, LSB first
    logic       s1_run, s2_run;
    logic [2:0] s1_idx, s2_idx;

    always_ff @(posedge clk) begin
        if (rst || !if1.ser_en) begin
            s1_run <= 1'b0;
            s1_idx <= 3'd0;
        end else if (!s1_run) begin
            s1_run <= 1'b1;
            s1_idx <= 3'd0;
        end else begin
            s1_idx <= s1_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !if2.ser_en) begin
            s2_run <= 1'b0;
            s2_idx <= 3'd0;
        end else if (!s2_run) begin
            s2_run <= 1'b1;
            s2_idx <= 3'd0;
        end else begin
            s2_idx <= s2_idx + 3'd1;
        end
    end

    assign if1.ser_data = s1_run & if1.SER_P_DATA[s1_idx];
    assign if1.ser_done = s1_run && (s1_idx == 3'd7);
    assign if2.ser_data = s2_run & if2.SER_P_DATA[s2_idx];
    assign if2.ser_done = s2_run && (s2_idx == 3'd7);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: per instance, a FIFO of the bits still to appear on
    // the line, each tagged with its kind (0 start, 1 data, 2 parity, 3 stop).
    // The head is the bit whose state is currently active.
    logic [2:0] mq [2][16];
    int         mlen [2];
    logic       exp_tx [2];
    logic       exp_busy [2];
    logic       exp_sen [2];
    logic [7:0] exp_spd [2];

    task automatic push(input int d, input logic [2:0] v);
        mq[d][mlen[d]] = v;
        mlen[d]++;
    endtask

    task automatic model_step(input int d, input int sb);
        bit can;
        if (rst) begin
            mlen[d]     = 0;
            exp_tx[d]   = 1'b1;
            exp_busy[d] = 1'b0;
            exp_spd[d]  = 8'h00;
        end else begin
            can = (mlen[d] <= 1);
            if (mlen[d] > 0) begin
                exp_tx[d]   = mq[d][0][0];
                exp_busy[d] = 1'b1;
                for (int i = 0; i < 15; i++) mq[d][i] = mq[d][i+1];
                mlen[d]--;
            end else begin
                exp_tx[d]   = 1'b1;
                exp_busy[d] = 1'b0;
            end
            if (dv && can) begin
                exp_spd[d] = p_data;
                push(d, {2'd0, 1'b0});
                for (int i = 0; i < 8; i++) push(d, {2'd1, p_data[i]});
                if (pe) push(d, {2'd2, (^p_data) ^ pt});
                for (int i = 0; i < sb; i++) push(d, {2'd3, 1'b1});
            end
        end
        exp_sen[d] = (mlen[d] > 0) && (mq[d][0][2:1] <= 2'd1);
    endtask

    logic [31:0] cap1, cap2;
    int          cap1_busy, cap2_busy;
    bit          cap_on = 1'b0;

    task automatic step();
        @(posedge clk);
        model_step(0, 1);
        model_step(1, 2);
        #1;
        chk("dut1_tx",   if1.TX_OUT,     exp_tx[0]);
        chk("dut1_busy", if1.BUSY,       exp_busy[0]);
        chk("dut1_sen",  if1.ser_en,     exp_sen[0]);
        chk("dut1_spd",  if1.SER_P_DATA, exp_spd[0]);
        chk("dut2_tx",   if2.TX_OUT,     exp_tx[1]);
        chk("dut2_busy", if2.BUSY,       exp_busy[1]);
        chk("dut2_sen",  if2.ser_en,     exp_sen[1]);
        chk("dut2_spd",  if2.SER_P_DATA, exp_spd[1]);
        if (cap_on) begin
            cap1 = {cap1[30:0], if1.TX_OUT};
            cap2 = {cap2[30:0], if2.TX_OUT};
            cap1_busy += int'(if1.BUSY);
            cap2_busy += int'(if2.BUSY);
        end
    endtask

    task automatic cap_start();
        cap1 = '0; cap2 = '0; cap1_busy = 0; cap2_busy = 0; cap_on = 1'b1;
    endtask

    // Accept one byte, release DATA_VALID, then capture n line cycles
    task automatic send_capture(input logic [7:0] b, input logic e, input logic t, input int n);
        dv = 1'b1; p_data = b; pe = e; pt = t;
        step();
        dv = 1'b0;
        cap_start();
        repeat (n) step();
        cap_on = 1'b0;
    endtask

    initial begin
        mlen[0] = 0; mlen[1] = 0;
        rst = 1'b1; dv = 1'b1; p_data = 8'h5A; pe = 1'b1; pt = 1'b0;

        // Reset held two cycles with DATA_VALID asserted
        repeat (2) step();
        chk("rst_tx",   if1.TX_OUT, 1'b1);
        chk("rst_busy", if1.BUSY,   1'b0);
        chk("rst_sen",  if1.ser_en, 1'b0);
        rst = 1'b0; dv = 1'b0;
        repeat (2) step();

        // 0xA5 even parity
        send_capture(8'hA5, 1'b1, 1'b0, 12);
        chk("a5_even_line", cap1, 32'b0101_0010_1011);
        chk("a5_even_busy", cap1_busy, 11);
        repeat (3) step();

        // 0xA5 odd parity
        send_capture(8'hA5, 1'b1, 1'b1, 12);
        chk("a5_odd_line", cap1, 32'b0101_0010_1111);
        repeat (3) step();

        // 0x00 without parity: 10-cycle frame
        send_capture(8'h00, 1'b0, 1'b0, 11);
        chk("zero_line", cap1, 32'b000_0000_0011);
        chk("zero_busy", cap1_busy, 10);
        repeat (3) step();

        // Back-to-back 0x55 then 0x0F with DATA_VALID held
        dv = 1'b1; p_data = 8'h55; pe = 1'b0; pt = 1'b0;
        step();
        cap_start();
        p_data = 8'h0F;
        repeat (11) step();
        dv = 1'b0;
        repeat (9) step();
        cap_on = 1'b0;
        chk("b2b_line", cap1, 32'b0101010101_0111100001);
        chk("b2b_busy", cap1_busy, 20);
        repeat (4) step();

        // Two stop bits, 0xFF, with a mid-DATA strobe and P_DATA change
        dv = 1'b1; p_data = 8'hFF; pe = 1'b0; pt = 1'b0;
        step();
        dv = 1'b0;
        cap_start();
        repeat (3) step();
        dv = 1'b1; p_data = 8'h00; pe = 1'b1; pt = 1'b1;
        step();
        dv = 1'b0;
        repeat (8) step();
        cap_on = 1'b0;
        chk("sb2_ff_line", cap2, 32'b0111_1111_1111);
        chk("sb2_ff_busy", cap2_busy, 11);
        chk("sb2_ff_spd",  if2.SER_P_DATA, 8'hFF);
        repeat (3) step();

        // Reset while the 4th data bit is on the line, then a fresh frame
        dv = 1'b1; p_data = 8'h3C; pe = 1'b1; pt = 1'b0;
        step();
        dv = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("midrst_tx",   if1.TX_OUT, 1'b1);
        chk("midrst_busy", if1.BUSY,   1'b0);
        rst = 1'b0;
        step();
        chk("postrst_tx", if1.TX_OUT, 1'b1);
        send_capture(8'hC3, 1'b1, 1'b1, 12);
        chk("postrst_line", cap1, 32'b0110_0001_1111);
        repeat (3) step();

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 249) == 0);
            dv     = ($urandom_range(0, 2) == 0);
            p_data = 8'($urandom);
            pe     = 1'($urandom);
            pt     = 1'($urandom);
            step();
        end
        rst = 1'b0; dv = 1'b0;
        repeat (15) step();
        chk("end_idle_busy1", if1.BUSY, 1'b0);
        chk("end_idle_busy2", if2.BUSY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
